// File: rtl/sme_job_sequencer_if.sv
// rtl/sme_job_sequencer_if.sv - host load/result and SME engine signals of the job sequencer
interface sme_job_sequencer_if #(
    parameter int MAX_STR = 32,
    parameter int NUM_PAT = 4
) ();
    localparam int PW = $clog2(NUM_PAT);
    localparam int IW = $clog2(MAX_STR);

    logic          wr_en;
    logic          wr_sel;
    logic [7:0]    wr_char;
    logic          wr_last;
    logic          start;
    logic          busy;
    logic          ovf;
    logic          res_valid;
    logic [PW-1:0] res_pat_id;
    logic          res_match;
    logic [IW-1:0] res_index;
    logic          res_timeout;
    logic          done;
    logic [7:0]    eng_chardata;
    logic          eng_isstring;
    logic          eng_ispattern;
    logic          eng_valid;
    logic          eng_match;
    logic [IW-1:0] eng_match_index;

    modport slave (
        input  wr_en, wr_sel, wr_char, wr_last, start,
        input  eng_valid, eng_match, eng_match_index,
        output busy, ovf, res_valid, res_pat_id, res_match, res_index, res_timeout, done,
        output eng_chardata, eng_isstring, eng_ispattern
    );

    modport master (
        output wr_en, wr_sel, wr_char, wr_last, start,
        output eng_valid, eng_match, eng_match_index,
        input  busy, ovf, res_valid, res_pat_id, res_match, res_index, res_timeout, done,
        input  eng_chardata, eng_isstring, eng_ispattern
    );
endinterface

// File: rtl/sme_job_sequencer.sv
// rtl/sme_job_sequencer.sv - batch sequencer replaying one string and N patterns into an SME engine
// Optional engine-response watchdog enabled by defining SEQ_TIMEOUT_EN.
module sme_job_sequencer #(
    parameter int MAX_STR = 32,
    parameter int MAX_PAT = 8,
    parameter int NUM_PAT = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    sme_job_sequencer_if.slave bus
);
    localparam int SW = $clog2(MAX_STR + 1);
    localparam int CW = $clog2(MAX_STR);
    localparam int XW = $clog2(MAX_PAT);
    localparam int LW = $clog2(MAX_PAT + 1);
    localparam int NW = $clog2(NUM_PAT + 1);
    localparam int PW = $clog2(NUM_PAT);

    localparam logic [2:0] S_LOAD = 3'd0;
    localparam logic [2:0] S_STR  = 3'd1;
    localparam logic [2:0] S_PAT  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pat_q, pat_d;
    logic [NW-1:0] num_pat_q, num_pat_d;
    logic [SW-1:0] str_len_q, str_len_d;
    logic [NW-1:0] pat_cnt_q, pat_cnt_d;
    logic [LW-1:0] plen_q [NUM_PAT];
    logic [LW-1:0] plen_d [NUM_PAT];
    logic [7:0]    str_mem_q [MAX_STR];
    logic [7:0]    str_mem_d [MAX_STR];
    logic [7:0]    pat_mem_q [NUM_PAT][MAX_PAT];
    logic [7:0]    pat_mem_d [NUM_PAT][MAX_PAT];
    logic          ovf_q, ovf_d;
    logic          match_q, match_d;
    logic [CW-1:0] index_q, index_d;
    logic [7:0]    eng_chardata_q, eng_chardata_d;
    logic          eng_isstring_q, eng_isstring_d;
    logic          eng_ispattern_q, eng_ispattern_d;
    logic [PW-1:0] wslot;
    logic          open_slot;
    logic [NW-1:0] total_pat;
    logic          timed_out;
    logic          res_valid;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          tmo_q, tmo_d;
    assign timed_out = tmo_q;
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        num_pat_d = num_pat_q;
        str_len_d = str_len_q;
        pat_cnt_d = pat_cnt_q;
        plen_d    = plen_q;
        str_mem_d = str_mem_q;
        pat_mem_d = pat_mem_q;
        ovf_d     = ovf_q;
        match_d   = match_q;
        index_d   = index_q;
        wslot     = pat_cnt_q[PW-1:0];
        open_slot = 1'b0;
        total_pat = '0;
`ifdef SEQ_TIMEOUT_EN
        tmo_d      = tmo_q;
        wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + TW'(1) : '0;
`endif
        case (state_q)
            S_LOAD: begin
                if (bus.wr_en) begin
                    if (!bus.wr_sel) begin
                        if (str_len_q == SW'(MAX_STR)) begin
                            ovf_d = 1'b1;
                        end else begin
                            str_mem_d[str_len_q[CW-1:0]] = bus.wr_char;
                            str_len_d = str_len_q + SW'(1);
                        end
                    end else if (pat_cnt_q == NW'(NUM_PAT)) begin
                        ovf_d = 1'b1;
                    end else begin
                        if (plen_q[wslot] == LW'(MAX_PAT)) begin
                            ovf_d = 1'b1;
                        end else begin
                            pat_mem_d[wslot][plen_q[wslot][XW-1:0]] = bus.wr_char;
                            plen_d[wslot] = plen_q[wslot] + LW'(1);
                        end
                        if (bus.wr_last) pat_cnt_d = pat_cnt_q + NW'(1);
                    end
                end
                // start sees the buffers as updated by a same-cycle write
                open_slot = (pat_cnt_d < NW'(NUM_PAT)) && (plen_d[pat_cnt_d[PW-1:0]] != '0);
                total_pat = pat_cnt_d + NW'(open_slot);
                if (bus.start && str_len_d != '0 && total_pat != '0) begin
                    state_d   = S_STR;
                    cnt_d     = '0;
                    num_pat_d = total_pat;
                end
            end
            S_STR: begin
                if (SW'(cnt_q) + SW'(1) == str_len_q) begin
                    state_d = S_PAT;
                    pat_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PAT: begin
                if (LW'(cnt_q) + LW'(1) == plen_q[pat_q]) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (bus.eng_valid) begin
                    match_d = bus.eng_match;
                    index_d = bus.eng_match ? bus.eng_match_index : '0;
                    state_d = S_EMIT;
`ifdef SEQ_TIMEOUT_EN
                    tmo_d   = 1'b0;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    match_d = 1'b0;
                    index_d = '0;
                    tmo_d   = 1'b1;
                    state_d = S_EMIT;
`endif
                end
            end
            S_EMIT: begin
                // a timed-out engine is in an unknown state, so the rest of the batch is dropped
                if (timed_out || NW'(pat_q) + NW'(1) == num_pat_q) begin
                    state_d = S_DONE;
                end else begin
                    pat_d   = pat_q + PW'(1);
                    cnt_d   = '0;
                    state_d = S_PAT;
                end
            end
            S_DONE: begin
                state_d   = S_LOAD;
                ovf_d     = 1'b0;
                str_len_d = '0;
                pat_cnt_d = '0;
                plen_d    = '{default: '0};
            end
            default: state_d = S_LOAD;
        endcase

        eng_isstring_d  = (state_d == S_STR);
        eng_ispattern_d = (state_d == S_PAT);
        eng_chardata_d  = 8'd0;
        if (eng_isstring_d) begin
            eng_chardata_d = str_mem_d[cnt_d];
        end else if (eng_ispattern_d) begin
            eng_chardata_d = pat_mem_d[pat_d][cnt_d[XW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_LOAD;
            cnt_q           <= '0;
            pat_q           <= '0;
            num_pat_q       <= '0;
            str_len_q       <= '0;
            pat_cnt_q       <= '0;
            plen_q          <= '{default: '0};
            ovf_q           <= 1'b0;
            match_q         <= 1'b0;
            index_q         <= '0;
            eng_chardata_q  <= 8'd0;
            eng_isstring_q  <= 1'b0;
            eng_ispattern_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_q      <= '0;
            tmo_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pat_q           <= pat_d;
            num_pat_q       <= num_pat_d;
            str_len_q       <= str_len_d;
            pat_cnt_q       <= pat_cnt_d;
            plen_q          <= plen_d;
            ovf_q           <= ovf_d;
            match_q         <= match_d;
            index_q         <= index_d;
            eng_chardata_q  <= eng_chardata_d;
            eng_isstring_q  <= eng_isstring_d;
            eng_ispattern_q <= eng_ispattern_d;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_q      <= wait_cnt_d;
            tmo_q           <= tmo_d;
`endif
        end
        str_mem_q <= str_mem_d;
        pat_mem_q <= pat_mem_d;
    end

    assign res_valid         = (state_q == S_EMIT);
    assign bus.res_valid     = res_valid;
    assign bus.res_pat_id    = res_valid ? pat_q : '0;
    assign bus.res_match     = res_valid & match_q;
    assign bus.res_index     = res_valid ? index_q : '0;
    assign bus.res_timeout   = res_valid & timed_out;
    assign bus.busy          = (state_q != S_LOAD) && (state_q != S_DONE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.ovf           = ovf_q;
    assign bus.eng_chardata  = eng_chardata_q;
    assign bus.eng_isstring  = eng_isstring_q;
    assign bus.eng_ispattern = eng_ispattern_q;
endmodule
